// File: rtl/datapath_ctrl_if.sv
// Instruction-issue and datapath-control bundle between an issuer and datapath_ctrl.
// Latency: n/a (wires only); instr_* is a valid/ready handshake, the rest are control outputs.
// Backpressure: the issuer holds instr_valid until instr_ready is seen high at a clock edge.
// Ports: instr_valid/instr/instr_ready handshake; opcode, sel_a, sel_b, imm, imm_sel,
//        reg_enable, flag_en, done, illegal, retired driven by the controller.
interface datapath_ctrl_if;
    logic        instr_valid;
    logic [19:0] instr;
    logic        instr_ready;
    logic [7:0]  opcode;
    logic [3:0]  sel_a;
    logic [3:0]  sel_b;
    logic [3:0]  imm;
    logic        imm_sel;
    logic [15:0] reg_enable;
    logic        flag_en;
    logic        done;
    logic        illegal;
    logic [15:0] retired;

    // Issuer side
    modport master (
        output instr_valid, instr,
        input  instr_ready, opcode, sel_a, sel_b, imm, imm_sel,
               reg_enable, flag_en, done, illegal, retired
    );

    // Controller side
    modport slave (
        input  instr_valid, instr,
        output instr_ready, opcode, sel_a, sel_b, imm, imm_sel,
               reg_enable, flag_en, done, illegal, retired
    );
endinterface

// File: rtl/datapath_ctrl.sv
// Four-state instruction sequencer driving ALU mux selects, register/flag write enables.
// Latency: accept at edge N -> DECODE N+1, EXEC N+2, WRITE N+3, ready again N+4.
// Backpressure: instr_ready only in IDLE; instr_valid while busy is ignored.
// Ports: clk, reset (sync, active-high); bus (slave modport of datapath_ctrl_if) carrying
//        the instruction handshake and all control outputs.
module datapath_ctrl (
    input  logic             clk,
    input  logic             reset,
    datapath_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WRITE  = 2'd3
    } state_t;

    localparam logic [7:0] OP_CMP  = 8'h0A;
    localparam logic [7:0] OP_CMPI = 8'h0B;
    localparam logic [7:0] OP_CMPU = 8'h0C;
    localparam logic [7:0] OP_NOP  = 8'h17;
    localparam logic [7:0] OP_FLAG_MAX = 8'h10;

    state_t      state_q, state_d;
    logic [19:0] instr_q, instr_d;
    logic [15:0] retired_q, retired_d;

    logic [7:0]  lat_op;
    logic [3:0]  lat_rdest;
    logic [3:0]  lat_rsrc;
    logic [3:0]  lat_imm;
    logic        op_legal;
    logic        op_imm;
    logic        op_writes;

    assign lat_op    = instr_q[19:12];
    assign lat_rdest = instr_q[11:8];
    assign lat_rsrc  = instr_q[7:4];
    assign lat_imm   = instr_q[3:0];

    // Opcode classification from the latched instruction
    always_comb begin
        op_legal = (lat_op <= OP_NOP);
        op_imm   = 1'b0;
        case (lat_op)
            8'h01, 8'h03, 8'h06, 8'h07, 8'h09, 8'h0B, 8'h12, 8'h14: op_imm = 1'b1;
            default: op_imm = 1'b0;
        endcase
        // Compares and NOP only touch flags (or nothing), never a register
        op_writes = op_legal && (lat_op != OP_CMP) && (lat_op != OP_CMPI) &&
                    (lat_op != OP_CMPU) && (lat_op != OP_NOP);
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    instr_d = bus.instr;
                    state_d = DECODE;
                end
            end
            DECODE: state_d = EXEC;
            EXEC:   state_d = WRITE;
            WRITE: begin
                state_d   = IDLE;
                retired_d = retired_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    // Outputs: idle presents a NOP with zeroed selects; busy states expose the latched fields
    always_comb begin
        bus.instr_ready = 1'b0;
        bus.opcode      = OP_NOP;
        bus.sel_a       = 4'd0;
        bus.sel_b       = 4'd0;
        bus.imm         = 4'd0;
        bus.imm_sel     = 1'b0;
        bus.reg_enable  = 16'd0;
        bus.flag_en     = 1'b0;
        bus.done        = 1'b0;
        bus.illegal     = 1'b0;
        bus.retired     = retired_q;
        if (state_q == IDLE) begin
            bus.instr_ready = 1'b1;
        end else begin
            bus.opcode  = lat_op;
            bus.sel_a   = lat_rdest;
            bus.sel_b   = lat_rsrc;
            bus.imm     = lat_imm;
            bus.imm_sel = op_imm;
        end
        if (state_q == EXEC && lat_op <= OP_FLAG_MAX) begin
            bus.flag_en = 1'b1;
        end
        if (state_q == WRITE) begin
            bus.done    = 1'b1;
            bus.illegal = !op_legal;
            if (op_writes) begin
                bus.reg_enable = 16'd1 << lat_rdest;
            end
        end
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
module tb_datapath_ctrl;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;
    logic [15:0] exp_ret;

    datapath_ctrl_if bus();

    datapath_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".ready"},   32'(bus.instr_ready), 32'd1);
        check({tag, ".opcode"},  32'(bus.opcode),      32'h17);
        check({tag, ".sel_a"},   32'(bus.sel_a),       32'd0);
        check({tag, ".sel_b"},   32'(bus.sel_b),       32'd0);
        check({tag, ".imm"},     32'(bus.imm),         32'd0);
        check({tag, ".imm_sel"}, 32'(bus.imm_sel),     32'd0);
        check({tag, ".reg_en"},  32'(bus.reg_enable),  32'd0);
        check({tag, ".flag_en"}, 32'(bus.flag_en),     32'd0);
        check({tag, ".done"},    32'(bus.done),        32'd0);
        check({tag, ".illegal"}, 32'(bus.illegal),     32'd0);
        check({tag, ".retired"}, 32'(bus.retired),     32'(exp_ret));
    endtask

    // Issues one instruction from IDLE and checks every cycle through the return to IDLE.
    task automatic run_instr(input string name, input logic [19:0] ins,
                             input logic [15:0] e_re, input logic e_fe,
                             input logic e_is, input logic e_ill);
        @(negedge clk);
        check({name, ".pre_ready"}, 32'(bus.instr_ready), 32'd1);
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        @(negedge clk);                          // DECODE
        bus.instr_valid = 1'b0;
        bus.instr       = 20'hA5A5A;             // need not be held after transfer
        check({name, ".dec_ready"},  32'(bus.instr_ready), 32'd0);
        check({name, ".opcode"},     32'(bus.opcode),      32'(ins[19:12]));
        check({name, ".sel_a"},      32'(bus.sel_a),       32'(ins[11:8]));
        check({name, ".sel_b"},      32'(bus.sel_b),       32'(ins[7:4]));
        check({name, ".imm"},        32'(bus.imm),         32'(ins[3:0]));
        check({name, ".imm_sel"},    32'(bus.imm_sel),     32'(e_is));
        check({name, ".dec_fe"},     32'(bus.flag_en),     32'd0);
        check({name, ".dec_done"},   32'(bus.done),        32'd0);
        @(negedge clk);                          // EXEC
        check({name, ".exe_fe"},     32'(bus.flag_en),     32'(e_fe));
        check({name, ".exe_re"},     32'(bus.reg_enable),  32'd0);
        check({name, ".exe_done"},   32'(bus.done),        32'd0);
        check({name, ".exe_sel_a"},  32'(bus.sel_a),       32'(ins[11:8]));
        @(negedge clk);                          // WRITE
        check({name, ".wr_re"},      32'(bus.reg_enable),  32'(e_re));
        check({name, ".wr_done"},    32'(bus.done),        32'd1);
        check({name, ".wr_illegal"}, 32'(bus.illegal),     32'(e_ill));
        check({name, ".wr_fe"},      32'(bus.flag_en),     32'd0);
        check({name, ".wr_imm_sel"}, 32'(bus.imm_sel),     32'(e_is));
        check({name, ".wr_retired"}, 32'(bus.retired),     32'(exp_ret));
        @(negedge clk);                          // back in IDLE
        exp_ret = exp_ret + 16'd1;
        check_idle({name, ".post"});
    endtask

    typedef struct {
        string       name;
        logic [19:0] ins;
        logic [15:0] re;
        logic        fe;
        logic        is;
        logic        ill;
    } vec_t;

    vec_t vecs[10];
    int   acc_cnt;
    int   acc_idx[2];

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        exp_ret = 16'd0;
        bus.instr_valid = 1'b0;
        bus.instr       = 20'd0;
        reset = 1'b1;

        vecs[0] = '{"add",    20'h00350, 16'h0008, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{"addi",   20'h01207, 16'h0004, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{"cmp",    20'h0A140, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{"lshi",   20'h12F02, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{"bad_ff", 20'hFF123, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{"op10",   20'h10A11, 16'h0400, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{"op11",   20'h11000, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{"nop",    20'h17965, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{"bad_18", 20'h18500, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{"cmpi",   20'h0B2C3, 16'h0000, 1'b1, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        check_idle("rst_hold");
        reset = 1'b0;
        @(negedge clk);
        check_idle("rst_state");

        foreach (vecs[i]) begin
            run_instr(vecs[i].name, vecs[i].ins, vecs[i].re, vecs[i].fe, vecs[i].is, vecs[i].ill);
        end

        // Preload the counter to exercise the wrap, then retire one instruction
        @(negedge clk);
        dut.retired_q = 16'hFFFF;
        exp_ret       = 16'hFFFF;
        run_instr("wrap", 20'h00350, 16'h0008, 1'b1, 1'b0, 1'b0);
        check("wrap.zero", 32'(bus.retired), 32'd0);

        // Valid held for 8 cycles: expect acceptances at sample 0 and 4 only
        acc_cnt = 0;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = 20'h02310;
        for (int i = 0; i < 8; i++) begin
            if (bus.instr_ready) begin
                if (acc_cnt < 2) acc_idx[acc_cnt] = i;
                acc_cnt++;
            end
            @(negedge clk);
        end
        bus.instr_valid = 1'b0;
        exp_ret = exp_ret + 16'd2;
        check("tput.count", 32'(acc_cnt), 32'd2);
        check("tput.gap",   32'(acc_idx[1] - acc_idx[0]), 32'd4);
        check_idle("tput.post");

        // Reset during EXEC aborts the instruction
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = 20'h00350;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check("rexe.in_exec", 32'(bus.flag_en), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        exp_ret = 16'd0;
        check_idle("rexe.after");
        reset = 1'b0;
        @(negedge clk);
        check_idle("rexe.next");
        @(negedge clk);
        check("rexe.no_done", 32'(bus.done), 32'd0);

        // Reset wins over a simultaneous instr_valid
        bus.instr_valid = 1'b1;
        bus.instr       = 20'h01207;
        reset           = 1'b1;
        @(negedge clk);
        reset           = 1'b0;
        bus.instr_valid = 1'b0;
        check_idle("rprio");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/datapath_ctrl.md
DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and reset.
REQ-002 The block SHALL expose these ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- instr_valid  in  1  instruction offered
- instr  in  20  instruction: [19:12] opcode, [11:8] rdest, [7:4] rsrc, [3:0] imm4
- instr_ready  out  1  block can accept an instruction
- opcode  out  8  ALU operation select
- sel_a  out  4  A-port register-mux select
- sel_b  out  4  B-port register-mux select
- imm  out  4  immediate field to the ALU B-mux
- imm_sel  out  1  B-mux takes imm instead of the register
- reg_enable  out  16  one-hot register write enable
- flag_en  out  1  flag-register load enable
- done  out  1  one-cycle retire pulse
- illegal  out  1  one-cycle pulse, illegal opcode retired
- retired  out  16  count of retired instructions

Function
REQ-003 The FSM SHALL have four states: IDLE, DECODE, EXEC, WRITE.
REQ-004 instr_ready SHALL be 1 only in IDLE.
REQ-005 A transfer SHALL occur on a clk edge with instr_valid & instr_ready; instr is latched into an internal register and the FSM goes to DECODE.
REQ-006 instr_valid without instr_ready SHALL be ignored; instr need not be held stable after the transfer.
REQ-007 Transitions SHALL be unconditional: DECODE->EXEC->WRITE->IDLE, one cycle each.
REQ-008 From the cycle after acceptance until the FSM leaves WRITE, opcode, sel_a, sel_b, imm and imm_sel SHALL be driven from the latched instruction:
- sel_a = rdest
- sel_b = rsrc
- imm = imm4
REQ-009 imm_sel SHALL be 1 for these opcodes and 0 otherwise: 0x01, 0x03, 0x06, 0x07, 0x09, 0x0B, 0x12, 0x14.
REQ-010 In WRITE, reg_enable SHALL be one-hot at bit rdest for legal opcodes other than CMP (0x0A), CMPI (0x0B), CMPU (0x0C) and NOP (0x17); in every other state and case it SHALL be 0.
REQ-011 flag_en SHALL be 1 only in EXEC, and only for opcodes 0x00-0x10.
REQ-012 Opcodes greater than 0x17 SHALL be illegal:
- no reg_enable, no flag_en
- illegal and done pulse together in WRITE
REQ-013 done SHALL pulse for exactly the WRITE cycle of every instruction, legal or illegal.
REQ-014 retired SHALL increment by 1 on the clk edge ending each WRITE, wrapping 0xFFFF->0x0000.
REQ-015 Latency SHALL be fixed: acceptance at edge N puts WRITE in cycle N+3, and instr_ready returns in cycle N+4 (sustained throughput is one instruction per 4 cycles).
REQ-016 When no instruction is in flight (IDLE), opcode SHALL be 0x17 (NOP) and sel_a, sel_b, imm, imm_sel SHALL be 0.
REQ-017 reset SHALL take priority over a simultaneous instr_valid; the instruction is not accepted.

Reset
REQ-018 On a clk edge with reset=1, the block SHALL:
- enter IDLE
- clear the latched instruction and retired to 0
- return all outputs to their IDLE values: instr_ready=1, opcode=0x17, all else 0
REQ-019 Reset in any state SHALL abort the in-flight instruction:
- no reg_enable, flag_en, done or illegal in the following cycle
- retired is not incremented

Verification
REQ-020 The bench SHALL cover at least these directed scenarios:
- ADD r3,r5 (instr=0x00350) accepted at edge N -> sel_a=3, sel_b=5, imm_sel=0; flag_en=1 in cycle N+2; reg_enable=0x0008 and done=1 in cycle N+3; retired=1.
- ADDI r2,#7 (0x01207) -> imm_sel=1, imm=7; reg_enable=0x0004 in WRITE; flag_en=1 in EXEC.
- CMP r1,r4 (0x0A140) -> flag_en=1; reg_enable stays 0x0000; done=1; retired increments.
- LSHI r15,#2 (0x12F02) -> imm_sel=1; flag_en=0; reg_enable=0x8000; opcode 0xFF -> illegal=1 and done=1 in WRITE, reg_enable=0, flag_en=0.
- instr_valid held high for 8 cycles -> exactly 2 acceptances 4 cycles apart; retired preloaded to 0xFFFF wraps to 0x0000 on the next retire.
- reset asserted in EXEC -> next cycle IDLE, instr_ready=1, reg_enable=0, done=0, retired=0.
